// File: rtl/fb_pkg.sv
// Shared definitions for the 32x32 one-bit framebuffer: op codes, controller
// states, default geometry and the CPU-side port addresses.
package fb_pkg;

  localparam int FB_W = 32;
  localparam int FB_H = 32;

  typedef enum logic [1:0] {
    FB_OP_DRAW  = 2'd0,
    FB_OP_ERASE = 2'd1,
    FB_OP_CLEAR = 2'd2,
    FB_OP_SWAP  = 2'd3
  } fb_op_t;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    CLEAR = 2'd2,
    COPY  = 2'd3
  } fb_state_t;

  // I/O addresses decoded on the CPU side into cmd_op
  localparam logic [7:0] FB_PORT_DRAW  = 8'd242;
  localparam logic [7:0] FB_PORT_ERASE = 8'd243;
  localparam logic [7:0] FB_PORT_CLEAR = 8'd245;
  localparam logic [7:0] FB_PORT_SWAP  = 8'd246;

  function automatic fb_op_t fb_port_to_op(input logic [7:0] port);
    case (port)
      FB_PORT_ERASE: fb_port_to_op = FB_OP_ERASE;
      FB_PORT_CLEAR: fb_port_to_op = FB_OP_CLEAR;
      FB_PORT_SWAP:  fb_port_to_op = FB_OP_SWAP;
      default:       fb_port_to_op = FB_OP_DRAW;
    endcase
  endfunction

endpackage

// File: rtl/fb_row_mem.sv
// H x W row-addressed bit storage: one write port (whole row, or a single
// bit set/clear) and one registered read port.
module fb_row_mem
  import fb_pkg::*;
#(
  parameter int W = FB_W,
  parameter int H = FB_H
) (
  input  logic                 clkin,
  input  logic                 rst_n,
  input  logic                 row_we,
  input  logic [$clog2(H)-1:0] wr_row,
  input  logic [W-1:0]         row_data,
  input  logic                 bit_we,
  input  logic [$clog2(W)-1:0] bit_x,
  input  logic                 bit_val,
  input  logic                 rd_en,
  input  logic [$clog2(H)-1:0] rd_row,
  output logic [W-1:0]         rd_data
);

  logic [W-1:0] mem [H];

  // Storage has no reset; the controller zeroes it row by row after reset.
  always_ff @(posedge clkin) begin
    if (row_we) begin
      mem[wr_row] <= row_data;
    end else if (bit_we) begin
      mem[wr_row][bit_x] <= bit_val;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_row];
    end
  end

endmodule

// File: rtl/fb_scan_ctrl.sv
// Framebuffer controller: sequences init/clear/copy over back and front row
// memories and arbitrates the front buffer between copy and row scanout.
module fb_scan_ctrl
  import fb_pkg::*;
#(
  parameter int W  = FB_W,
  parameter int H  = FB_H,
  parameter int XW = $clog2(W),
  parameter int YW = $clog2(H)
) (
  input  logic          clkin,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [XW-1:0] cmd_x,
  input  logic [YW-1:0] cmd_y,
  output logic          busy,
  output logic          frame_done,
  input  logic          scan_req,
  input  logic [YW-1:0] scan_row,
  output logic          scan_ack,
  output logic [W-1:0]  scan_data,
  output fb_state_t     dbg_state
);

  localparam logic [YW-1:0] ROW_LAST   = YW'(H - 1);
  localparam logic [YW-1:0] ROW_PENULT = YW'(H - 2);

  fb_state_t     state;
  logic [YW-1:0] row;
  logic          row_last;
  logic          cmd_fire;
  logic          in_range;
  logic          pix_fire;
  logic          scan_fire;
  logic [W-1:0]  back_rd;

  // Handshakes: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is registered and only high in IDLE.
  // A scan request is taken in any IDLE/CLEAR cycle with scan_req high and no
  // ack showing, and scan_ack pulses for one cycle with scan_data valid.
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign in_range  = (32'(cmd_x) < W) && (32'(cmd_y) < H);
  assign pix_fire  = cmd_fire && in_range && !cmd_op[1];
  assign scan_fire = scan_req && !scan_ack && (state == IDLE || state == CLEAR);
  assign row_last  = (row == ROW_LAST);
  assign dbg_state = state;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      row        <= '0;
      cmd_ready  <= 1'b0;
      busy       <= 1'b1;
      frame_done <= 1'b0;
      scan_ack   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      scan_ack   <= scan_fire;
      case (state)
        INIT, CLEAR, COPY: begin
          if (row_last) begin
            state     <= IDLE;
            row       <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            row <= row + 1'b1;
            // frame_done lines up with the cycle that writes the last row
            if (state == COPY && row == ROW_PENULT) begin
              frame_done <= 1'b1;
            end
          end
        end
        IDLE: begin
          if (cmd_fire && cmd_op == FB_OP_CLEAR) begin
            state     <= CLEAR;
            row       <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end else if (cmd_fire && cmd_op == FB_OP_SWAP) begin
            state     <= COPY;
            row       <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Back read address runs one row ahead during COPY (row 0 is prefetched
  // while idle) so the registered read feeds the front write each cycle.
  fb_row_mem #(.W(W), .H(H)) u_back (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .row_we   (state == INIT || state == CLEAR),
    .wr_row   ((state == IDLE) ? cmd_y : row),
    .row_data ('0),
    .bit_we   (pix_fire),
    .bit_x    (cmd_x),
    .bit_val  (cmd_op == FB_OP_DRAW),
    .rd_en    (1'b1),
    .rd_row   ((state == COPY) ? YW'(row + 1'b1) : '0),
    .rd_data  (back_rd)
  );

  fb_row_mem #(.W(W), .H(H)) u_front (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .row_we   (state == INIT || state == COPY),
    .wr_row   (row),
    .row_data ((state == COPY) ? back_rd : '0),
    .bit_we   (1'b0),
    .bit_x    ('0),
    .bit_val  (1'b0),
    .rd_en    (scan_fire),
    .rd_row   (scan_row),
    .rd_data  (scan_data)
  );

endmodule

// File: tb/tb_fb_scan_ctrl.sv
// Directed bench for fb_scan_ctrl: reset/init timing, draw/erase/clear/swap,
// scanout latency and stalling during copy, and reset in the middle of a copy.
module tb_fb_scan_ctrl;
  import fb_pkg::*;

  logic        clkin;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_x;
  logic [4:0]  cmd_y;
  logic        busy;
  logic        frame_done;
  logic        scan_req;
  logic [4:0]  scan_row;
  logic        scan_ack;
  logic [31:0] scan_data;
  fb_state_t   dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [31:0] exp_q[$];

  fb_scan_ctrl dut (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .busy       (busy),
    .frame_done (frame_done),
    .scan_req   (scan_req),
    .scan_row   (scan_row),
    .scan_ack   (scan_ack),
    .scan_data  (scan_data),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clkin);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cmd(input fb_op_t op, input logic [4:0] x, input logic [4:0] y);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = x;
    cmd_y     = y;
    while (!cmd_ready && n < 100) begin
      step();
      n++;
    end
    chk("cmd_ready", 32'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic scan(input logic [4:0] r, input logic [31:0] exp);
    int n;
    n = 0;
    exp_q.push_back(exp);
    scan_req = 1'b1;
    scan_row = r;
    do begin
      step();
      n++;
    end while (!scan_ack && n < 60);
    scan_req = 1'b0;
    chk($sformatf("scan_ack_row%0d", r), 32'(scan_ack), 1);
    chk($sformatf("scan_data_row%0d", r), scan_data, exp_q.pop_front());
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n, fd, fd_at, saw, early, idle_at, ack_at, c0;
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_x = '0;
    cmd_y = '0;
    scan_req = 1'b0;
    scan_row = '0;
    #2 rst_n = 1'b0;
    step();
    step();

    // reset values
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_scan_ack", 32'(scan_ack), 0);
    chk("rst_scan_data", scan_data, 0);
    chk("rst_state", 32'(dbg_state), 32'(INIT));

    // init: 32 busy cycles, scan request held but not acked meanwhile
    scan_req = 1'b1;
    scan_row = 5'd5;
    rst_n = 1'b1;
    n = 0;
    saw = 0;
    while (busy && n < 100) begin
      step();
      n++;
      if (busy && scan_ack) saw = 1;
    end
    chk("init_len", n, 32);
    chk("init_no_ack", saw, 0);
    chk("init_ready", 32'(cmd_ready), 1);
    step();
    chk("init_scan_ack", 32'(scan_ack), 1);
    chk("init_scan_data", scan_data, 0);
    scan_req = 1'b0;
    for (int r = 0; r < 32; r++) scan(5'(r), 32'h0);

    // draw two pixels and swap
    cmd(FB_OP_DRAW, 5'd5, 5'd3);
    cmd(FB_OP_DRAW, 5'd31, 5'd0);
    cmd(FB_OP_SWAP, 5'd0, 5'd0);
    chk("copy_busy", 32'(busy), 1);
    chk("copy_not_ready", 32'(cmd_ready), 0);
    n = 0;
    fd = 0;
    fd_at = -1;
    while (busy && n < 100) begin
      if (frame_done) begin
        fd++;
        fd_at = n;
      end
      step();
      n++;
    end
    chk("copy_len", n, 32);
    chk("frame_done_count", fd, 1);
    chk("frame_done_pos", fd_at, 31);
    chk("frame_done_low", 32'(frame_done), 0);
    scan(5'd3, 32'h0000_0020);
    scan(5'd0, 32'h8000_0000);
    scan(5'd31, 32'h0);

    // erase + clear without swap leaves the front buffer alone
    cmd(FB_OP_ERASE, 5'd5, 5'd3);
    cmd(FB_OP_CLEAR, 5'd0, 5'd0);
    c0 = cyc;
    chk("clear_state", 32'(dbg_state), 32'(CLEAR));
    scan(5'd0, 32'h8000_0000);
    wait_idle(n);
    chk("clear_len", cyc - c0, 32);
    scan(5'd3, 32'h0000_0020);
    cmd(FB_OP_SWAP, 5'd0, 5'd0);
    wait_idle(n);
    chk("swap2_len", n, 32);
    for (int r = 0; r < 32; r++) scan(5'(r), 32'h0);

    // scan request stalls through COPY and gets the post-copy row
    cmd(FB_OP_DRAW, 5'd9, 5'd3);
    cmd(FB_OP_SWAP, 5'd0, 5'd0);
    scan_req = 1'b1;
    scan_row = 5'd3;
    n = 0;
    early = 0;
    idle_at = -1;
    ack_at = -1;
    while (ack_at < 0 && n < 100) begin
      step();
      n++;
      if (!busy && idle_at < 0) idle_at = n;
      if (scan_ack) begin
        if (busy) early++;
        ack_at = n;
      end
    end
    scan_req = 1'b0;
    chk("stall_no_early_ack", early, 0);
    chk("stall_copy_len", idle_at, 32);
    chk("stall_ack_seen", 32'(scan_ack), 1);
    chk("stall_ack_window", 32'((ack_at > idle_at) && (ack_at - idle_at <= 2)), 1);
    chk("stall_scan_data", scan_data, 32'h0000_0200);

    // pixel command and scan in the same IDLE cycle
    step();
    cmd_valid = 1'b1;
    cmd_op = FB_OP_DRAW;
    cmd_x = 5'd12;
    cmd_y = 5'd7;
    scan_req = 1'b1;
    scan_row = 5'd7;
    step();
    cmd_valid = 1'b0;
    scan_req = 1'b0;
    chk("simul_scan_ack", 32'(scan_ack), 1);
    chk("simul_scan_data", scan_data, 32'h0);
    chk("simul_ready", 32'(cmd_ready), 1);
    chk("simul_busy", 32'(busy), 0);
    cmd(FB_OP_SWAP, 5'd0, 5'd0);
    wait_idle(n);
    scan(5'd7, 32'h0000_1000);
    scan(5'd3, 32'h0000_0200);

    // reset at COPY row 10
    cmd(FB_OP_DRAW, 5'd0, 5'd10);
    cmd(FB_OP_SWAP, 5'd0, 5'd0);
    repeat (10) step();
    chk("midcopy_state", 32'(dbg_state), 32'(COPY));
    rst_n = 1'b0;
    #1;
    chk("midrst_cmd_ready", 32'(cmd_ready), 0);
    chk("midrst_busy", 32'(busy), 1);
    chk("midrst_frame_done", 32'(frame_done), 0);
    chk("midrst_scan_ack", 32'(scan_ack), 0);
    chk("midrst_scan_data", scan_data, 0);
    chk("midrst_state", 32'(dbg_state), 32'(INIT));
    step();
    step();
    rst_n = 1'b1;
    wait_idle(n);
    chk("reinit_len", n, 32);
    for (int r = 0; r < 32; r++) scan(5'(r), 32'h0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fb_scan_ctrl.md
Name: fb_scan_ctrl

Overview:
- Controller and arbiter for the 32x32 one-bit screen framebuffer behind the CPU's display ports.
- Owns a back buffer (CPU draw target) and a front buffer (display source).
- Sequences the multi-cycle operations: clear back buffer, and copy back to front ("buffer screen").
- Arbitrates front-buffer access between the copy engine and a row-scanout requester (display driver).

Parameters:
W, 32, screen width in pixels (bits per row)
H, 32, screen height in rows
XW, $clog2(W), x coordinate width
YW, $clog2(H), y coordinate width

Ports:
clkin  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  CPU command strobe
cmd_ready  output  1  command accepted when valid&ready
cmd_op  input  2  0=DRAW pixel, 1=ERASE pixel, 2=CLEAR back buffer, 3=SWAP (copy back->front)
cmd_x  input  XW  pixel column (bit index in row)
cmd_y  input  YW  pixel row
busy  output  1  high whenever state != IDLE
frame_done  output  1  one-cycle pulse on the last COPY cycle
scan_req  input  1  scanout row request; held high until scan_ack
scan_row  input  YW  requested front-buffer row; stable while scan_req high
scan_ack  output  1  one-cycle pulse: scan_data valid
scan_data  output  W  front-buffer row contents

Behaviour:
- Reset is asynchronous on control registers only. Reset values: cmd_ready=0, busy=1, frame_done=0, scan_ack=0, scan_data=0. Row counter=0. State=INIT.
- States are INIT, IDLE, CLEAR, COPY.
- INIT: zero one row of both buffers per cycle, rows 0..H-1, then go to IDLE. Takes H cycles, so 32 cycles after rst_n deasserts, cmd_ready rises. Scan requests are not acked in INIT.
- IDLE: cmd_ready=1. DRAW and ERASE set or clear back[cmd_y][cmd_x] on the accept edge, state stays IDLE (single-cycle throughput).
- CLEAR accept: state becomes CLEAR, row counter resets to 0.
- SWAP accept: state becomes COPY, row counter resets to 0.
- CLEAR: back[row]=0 each cycle; row goes 0..H-1; IDLE after row H-1. Takes H cycles. cmd_ready=0.
- COPY: front[row]=back[row] each cycle; row goes 0..H-1. frame_done=1 in the cycle the transfer of row H-1 is registered; IDLE next. cmd_ready=0.
- Scanout port, served in IDLE and CLEAR:
  - Any cycle with scan_req high and no ack pending latches front[scan_row] into scan_data.
  - scan_ack pulses the following cycle (latency 1).
  - The requester must drop scan_req or present a new row after the ack. Back-to-back requests get one ack every 2 cycles.
- Scanout arbitration during COPY: the copy engine has priority on the front buffer. Scan requests stall (no ack) until COPY ends. A request pending at the last COPY cycle is served from the fully updated frame, acked 2 cycles after COPY exit at most. No torn rows are visible to scanout.
- Simultaneous events in IDLE: a pixel command and a scan request are both served in the same cycle; the back and front buffers are independent.
- Command accept and any state exit on the same edge: the new command is not accepted (cmd_ready is registered low while busy).
- cmd_valid while cmd_ready=0: ignored; the CPU must hold it.
- Out-of-range coordinates: impossible by width when W and H are powers of 2. Otherwise any x>=W or y>=H command is dropped but still handshaken.
- Row counter width is YW. Termination compares against H-1 with no wrap beyond.
- Reset asserted mid-CLEAR or mid-COPY: state returns to INIT and both buffers are re-zeroed. A partially copied front buffer is never displayed, because scan is blocked in INIT.

Decomposition:
- Shared package fb_pkg holds:
  - op codes FB_OP_DRAW, FB_OP_ERASE, FB_OP_CLEAR, FB_OP_SWAP
  - state enum fb_state_t (INIT, IDLE, CLEAR, COPY)
  - defaults FB_W=32, FB_H=32
  - CPU port addresses 242, 243, 245, 246, used by the CPU-side decoder that drives cmd_op
- One sub-module, fb_row_mem: an H x W row-addressed storage with one write port (row write plus optional single-bit set/clear) and one registered read port. It is instantiated twice (back, front).

Test Plan:
- Reset release -> busy=1 for exactly 32 cycles, then cmd_ready=1. Scanning rows 0..31 returns scan_data=0.
- DRAW (x=5,y=3), DRAW (x=31,y=0), SWAP -> COPY lasts 32 cycles with frame_done pulsed once. Scanning row 3 = 32'h0000_0020 and row 0 = 32'h8000_0000.
- ERASE (5,3), CLEAR, then no SWAP -> front unchanged: row 3 still 32'h0000_0020. After a SWAP, all 32 rows read 0.
- scan_req on row 3 asserted the cycle after SWAP accept -> no scan_ack during the 32 COPY cycles. Ack arrives no later than 2 cycles after COPY ends, carrying the post-copy value.
- DRAW in IDLE with simultaneous scan_req row 7 -> both complete: scan_ack next cycle, and the pixel is present in back (verified via a later SWAP).
- rst_n pulsed low at COPY row 10 -> outputs take their reset values immediately. INIT re-zeroes both buffers, and all scanned rows are 0 afterwards.
